// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg -- constants and types shared by the UART transmitter and receiver.
//
// Contents:
//   CLK_FREQ_HZ, BAUD, CLKS_PER_BIT : default timing (100 MHz, 115200 bps)
//   PAR_NONE, PAR_EVEN, PAR_ODD      : parity mode selectors
//   uart_state_e                     : frame state encoding
//   parity_bit()                     : parity bit for a byte and a mode
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int CLK_FREQ_HZ  = 100_000_000;
    localparam int BAUD         = 115_200;
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;  // 868 at the defaults

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even parity makes the total count of ones even, so the bit is the XOR
    // of the data; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] d, input int mode);
        return (^d) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen -- bit-period counter for the UART.
//
// Counts 0 .. CLKS_PER_BIT-1 and wraps. bit_end is high during the last
// cycle of every bit period. clear holds the counter at zero so a new frame
// always starts with a full-length first bit.
//
// Ports:
//   clk     : system clock
//   rst     : asynchronous, active-high reset
//   clear   : synchronous clear (counter held at 0 while high)
//   bit_end : high in the final cycle of a bit period
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
    end

    localparam int                CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_end = (cnt_q == LAST);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear || bit_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter -- serialises bytes onto an RS232 line.
//
// Frame: start bit (0), 8 data bits LSB first, optional parity bit, then
// STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT clocks. A byte is
// accepted on any edge where the block is idle and send is high.
//
// Ports:
//   clk     : system clock
//   rst     : asynchronous, active-high reset (aborts any frame)
//   data_in : byte to transmit, sampled only on accept
//   send    : transmit request
//   ready   : idle, a send will be accepted this cycle
//   busy    : a frame is on the line (always !ready)
//   done    : one-cycle pulse after the last stop bit completes
//   tx      : registered serial output, idle high
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int PARITY       = uart_pkg::PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_transmitter: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end

    uart_pkg::uart_state_e state_q, state_d;

    logic [7:0] shift_q;      // byte latched at accept; bits are selected by index
    logic [2:0] bit_idx_q;
    logic [2:0] bit_idx_d;
    logic       stop_idx_q;   // which stop bit is on the line when STOP_BITS == 2
    logic       tx_q, tx_d;
    logic       done_q, done_d;
    logic       bit_end;
    logic       accept;
    logic       last_stop;
    logic       baud_clear;

    assign accept     = (state_q == uart_pkg::IDLE) && send;
    assign last_stop  = (stop_idx_q == 1'(STOP_BITS - 1));
    // Holding the counter clear while idle means it is zero on the first
    // START cycle, with no phase left over from the previous frame.
    assign baud_clear = (state_q == uart_pkg::IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear),
        .bit_end (bit_end)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= uart_pkg::IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            uart_pkg::IDLE:   if (send) state_d = uart_pkg::START;
            uart_pkg::START:  if (bit_end) state_d = uart_pkg::DATA;
            uart_pkg::DATA:   if (bit_end && bit_idx_q == 3'd7) begin
                                  state_d = (PARITY != uart_pkg::PAR_NONE) ? uart_pkg::PARITY
                                                                           : uart_pkg::STOP;
                              end
            uart_pkg::PARITY: if (bit_end) state_d = uart_pkg::STOP;
            uart_pkg::STOP:   if (bit_end && last_stop) state_d = uart_pkg::IDLE;
            default:          state_d = uart_pkg::IDLE;
        endcase
    end

    // Data index for the next cycle: cleared on accept, stepped at each data
    // bit end (wrapping 7 -> 0 as DATA is left).
    always_comb begin
        bit_idx_d = bit_idx_q;
        if (accept) begin
            bit_idx_d = 3'd0;
        end else if (state_q == uart_pkg::DATA && bit_end) begin
            bit_idx_d = bit_idx_q + 3'd1;
        end
    end

    // Output logic: the line level and done for the next cycle, decoded from
    // the next state so that tx can be registered without adding latency.
    always_comb begin
        tx_d   = 1'b1;
        done_d = (state_q == uart_pkg::STOP) && (state_d == uart_pkg::IDLE);
        case (state_d)
            uart_pkg::START:  tx_d = 1'b0;
            uart_pkg::DATA:   tx_d = shift_q[bit_idx_d];
            uart_pkg::PARITY: tx_d = uart_pkg::parity_bit(shift_q, PARITY);
            default:          tx_d = 1'b1;
        endcase
    end

    // Frame datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            if (accept) begin
                shift_q    <= data_in;
                stop_idx_q <= 1'b0;
            end else if (state_q == uart_pkg::STOP && bit_end) begin
                stop_idx_q <= ~stop_idx_q;
            end
        end
    end

    assign tx    = tx_q;
    assign done  = done_q;
    assign ready = (state_q == uart_pkg::IDLE);
    assign busy  = ~ready;

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter -- scoreboard bench for uart_transmitter.
//
// Three transmitters with different framing run side by side, each with its
// own reset, stimulus and line monitor. Stimulus pushes {byte, accept cycle}
// into a per-instance queue; the monitor watches the line, pops an entry when
// a start bit appears and compares every line cycle against a reference
// frame built from the byte and the framing rules.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int NI = 3;
    localparam int          CPB_CFG  [NI] = '{16, 16, 2};
    localparam int          PAR_CFG  [NI] = '{0, 1, 2};
    localparam int          STOP_CFG [NI] = '{1, 2, 1};
    localparam logic [7:0]  DIR_BYTE [NI] = '{8'hA5, 8'h07, 8'h00};
    localparam int          FAIL_PRINT_MAX = 40;

    typedef struct {
        logic [7:0] data;
        int         accept_cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;        // posedges seen so far
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= FAIL_PRINT_MAX)
                $display("FAIL %s inst=%0d cyc=%0d got=0x%0h expected=0x%0h",
                         name, inst, cyc, act, exp);
        end
    endtask

    // Line image of a frame: bit k of the result is the level during bit
    // period k. Everything past the parity/data bits is high (stop/idle).
    function automatic logic [11:0] ref_frame(input logic [7:0] d, input int par);
        logic [11:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        if (par != 0) f[9] = (($countones(d) % 2) == 1) ^ (par == 2);
        return f;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int CPB   = CPB_CFG[g];
        localparam int PAR   = PAR_CFG[g];
        localparam int STOPS = STOP_CFG[g];
        localparam int NBITS = 9 + ((PAR != 0) ? 1 : 0) + STOPS;
        localparam int FRAME = NBITS * CPB;

        logic       rst = 1'b1;
        logic       send = 1'b0;
        logic [7:0] data_in = 8'h00;
        logic       ready, busy, done, tx;
        exp_t       exp_q[$];
        bit         fin = 1'b0;

        uart_transmitter #(
            .CLKS_PER_BIT (CPB),
            .PARITY       (PAR),
            .STOP_BITS    (STOPS)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .data_in (data_in),
            .send    (send),
            .ready   (ready),
            .busy    (busy),
            .done    (done),
            .tx      (tx)
        );

        // ---------------- monitor ----------------
        bit          in_frame = 1'b0;
        int          f_start = 0;
        exp_t        cur;
        logic [11:0] cur_bits;
        logic [7:0]  rx_byte;

        always @(negedge clk) begin
            int   off;
            logic exp_tx;
            logic exp_done;
            logic exp_ready;
            exp_tx   = 1'b1;
            exp_done = 1'b0;
            if (rst) begin
                in_frame = 1'b0;
                exp_q.delete();
            end else begin
                if (!in_frame && tx === 1'b0) begin
                    check("frame_expected", g, (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        cur      = exp_q.pop_front();
                        cur_bits = ref_frame(cur.data, PAR);
                        check("start_latency", g, cyc, cur.accept_cyc);
                        in_frame = 1'b1;
                        f_start  = cyc;
                    end
                end
                if (in_frame) begin
                    off = cyc - f_start;
                    if (off < FRAME) begin
                        exp_tx = cur_bits[off / CPB];
                        if ((off % CPB) == CPB / 2 && off / CPB >= 1 && off / CPB <= 8)
                            rx_byte[off / CPB - 1] = tx;
                    end else begin
                        exp_done = 1'b1;
                        check("rx_byte", g, rx_byte, cur.data);
                        in_frame = 1'b0;
                    end
                end
            end
            exp_ready = !in_frame;
            check("tx", g, tx, exp_tx);
            check("done", g, done, exp_done);
            check("ready", g, ready, exp_ready);
            check("busy", g, busy, !exp_ready);
        end

        // ---------------- stimulus ----------------
        // All tasks are entered and left just after a falling edge.
        task automatic wait_ready(output bit ok);
            int n;
            n = 0;
            while (ready !== 1'b1 && n < FRAME + 8) begin
                @(negedge clk);
                n++;
            end
            ok = (ready === 1'b1);
            check("ready_wait", g, ok, 1);
        endtask

        task automatic send_byte(input logic [7:0] d, input bit scramble);
            bit ok;
            wait_ready(ok);
            if (ok) begin
                send    = 1'b1;
                data_in = d;
                exp_q.push_back('{data: d, accept_cyc: cyc + 1});
                @(negedge clk);
                send = 1'b0;
                if (scramble) data_in = 8'($urandom);
            end
        endtask

        // send held high across a whole frame: the second byte must go out
        // exactly one cycle after the first frame's final stop cycle.
        task automatic send_b2b(input logic [7:0] d1, input logic [7:0] d2);
            bit ok;
            int a1;
            wait_ready(ok);
            if (ok) begin
                send    = 1'b1;
                data_in = d1;
                a1      = cyc + 1;
                exp_q.push_back('{data: d1, accept_cyc: a1});
                @(negedge clk);
                data_in = d2;
                wait_ready(ok);
                if (ok) begin
                    exp_q.push_back('{data: d2, accept_cyc: cyc + 1});
                    check("b2b_period", g, cyc + 1 - a1, FRAME + 1);
                    @(negedge clk);
                end
                send = 1'b0;
            end
        endtask

        task automatic send_ignored(input logic [7:0] d, input logic [7:0] junk);
            send_byte(d, 1'b0);
            repeat (FRAME / 2) @(negedge clk);
            send    = 1'b1;
            data_in = junk;
            @(negedge clk);
            send    = 1'b0;
        endtask

        task automatic drain();
            int n;
            n = 0;
            while ((exp_q.size() != 0 || in_frame || ready !== 1'b1) && n < 2 * FRAME + 10) begin
                @(negedge clk);
                n++;
            end
            check("drain", g, exp_q.size() + (in_frame ? 1 : 0), 0);
            repeat (CPB + 2) @(negedge clk);  // the line must stay idle here
        endtask

        initial begin
            logic [7:0] d;
            repeat (5) @(negedge clk);
            check("rst_hold_tx", g, tx, 1);
            check("rst_hold_ready", g, ready, 1);
            check("rst_hold_busy", g, busy, 0);
            check("rst_hold_done", g, done, 0);
            rst = 1'b0;
            repeat (4) @(negedge clk);
            check("rst_rel_tx", g, tx, 1);
            check("rst_rel_ready", g, ready, 1);

            send_byte(DIR_BYTE[g], 1'b1);
            drain();
            send_b2b(8'h55, 8'hAA);
            drain();
            send_ignored(8'h12, 8'hFF);
            drain();
            for (int i = 0; i < 6; i++) begin
                send_byte(8'($urandom), 1'b1);
                repeat ($urandom_range(3, 0)) @(negedge clk);
            end
            drain();

            // Abort a frame in the middle of data bit 3 (a 0 bit), between edges.
            d = 8'($urandom) & 8'hF7;
            send_byte(d, 1'b1);
            repeat (4 * CPB + CPB / 2) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            check("abort_tx", g, tx, 1);
            check("abort_ready", g, ready, 1);
            check("abort_busy", g, busy, 0);
            check("abort_done", g, done, 0);
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (2) @(negedge clk);
            send_byte(8'h3C, 1'b1);
            drain();

            check("queue_empty", g, exp_q.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("all_finished", 0, {g_inst[2].fin, g_inst[1].fin, g_inst[0].fin}, 3'b111);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
